// File: rtl/freelist_pkg.sv
// Shared defaults and types for the checkpointed physical-register free list.
package freelist_pkg;

    localparam int unsigned FL_WIDTH      = 3;
    localparam int unsigned FL_DEPTH      = 32;
    localparam int unsigned FL_PR_W       = 6;
    localparam int unsigned FL_NUM_CKPT   = 4;
    localparam int unsigned FL_RESET_BASE = 32;

    localparam int unsigned FL_IDX_W  = $clog2(FL_DEPTH);
    localparam int unsigned FL_CKPT_W = $clog2(FL_NUM_CKPT);

    // Free-list pointer: entry index plus one wrap bit in the MSB.
    typedef logic [FL_IDX_W:0] ptr_t;

    // Checkpoint slot selector.
    typedef logic [FL_CKPT_W-1:0] ckpt_id_t;

endpackage

// File: rtl/freelist_ckpt_lane_compact.sv
// Lane compaction: each set lane gets its rank among the set lanes below it.
module lane_compact #(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0]                   en,
    output logic [WIDTH*$clog2(WIDTH+1)-1:0]   offset,
    output logic [$clog2(WIDTH+1)-1:0]         count
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] run;

    // Running prefix count gives each lane its slot offset; the total is the popcount.
    always_comb begin
        run    = '0;
        offset = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            offset[i*CNT_W +: CNT_W] = run;
            run = run + CNT_W'(en[i]);
        end
        count = run;
    end

endmodule

// File: rtl/freelist_ckpt.sv
// Circular free list of physical register tags with head-pointer checkpoints
// for single-cycle branch-mispredict recovery.
module freelist_ckpt
    import freelist_pkg::*;
#(
    parameter int unsigned WIDTH     = FL_WIDTH,
    parameter int unsigned DEPTH     = FL_DEPTH,
    parameter int unsigned PR_W      = FL_PR_W,
    parameter int unsigned ARCH_REGS = FL_RESET_BASE,
    parameter int unsigned NUM_CKPT  = FL_NUM_CKPT
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              alloc_req,
    output logic                          alloc_gnt,
    output logic [WIDTH*PR_W-1:0]         alloc_tag,
    input  logic [WIDTH-1:0]              free_en,
    input  logic [WIDTH*PR_W-1:0]         free_tag,
    input  logic                          ckpt_save,
    input  logic [$clog2(NUM_CKPT)-1:0]   ckpt_save_id,
    input  logic                          ckpt_restore,
    input  logic [$clog2(NUM_CKPT)-1:0]   ckpt_restore_id,
    output logic [$clog2(DEPTH):0]        free_count,
    output logic                          empty
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned EXT_W = PTR_W + 1;

    logic [PR_W-1:0]        entry_q [DEPTH];
    logic [PTR_W-1:0]       chk_q   [NUM_CKPT];
    logic [PTR_W-1:0]       head_q;
    logic [PTR_W-1:0]       tail_q;
    logic [PTR_W-1:0]       head_next;
    logic [PTR_W-1:0]       tail_next;
    logic [PTR_W-1:0]       count_c;
    logic [PTR_W-1:0]       count_next;
    logic [WIDTH*CNT_W-1:0] alloc_off;
    logic [WIDTH*CNT_W-1:0] free_off;
    logic [CNT_W-1:0]       alloc_k;
    logic [CNT_W-1:0]       free_m;
    logic                   gnt_c;
    logic [EXT_W-1:0]       ovf_need_c;
    logic [EXT_W-1:0]       ovf_room_c;

    lane_compact #(.WIDTH(WIDTH)) u_alloc_compact (
        .en     (alloc_req),
        .offset (alloc_off),
        .count  (alloc_k)
    );

    lane_compact #(.WIDTH(WIDTH)) u_free_compact (
        .en     (free_en),
        .offset (free_off),
        .count  (free_m)
    );

    assign count_c   = tail_q - head_q;
    assign alloc_gnt = gnt_c;

    // All-or-nothing grant and per-lane tag lookup from the registered head.
    always_comb begin
        gnt_c     = !reset && !ckpt_restore && (PTR_W'(alloc_k) <= count_c);
        alloc_tag = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (gnt_c && alloc_req[i]) begin
                alloc_tag[i*PR_W +: PR_W] =
                    entry_q[IDX_W'(head_q[IDX_W-1:0] + IDX_W'(alloc_off[i*CNT_W +: CNT_W]))];
            end
        end
    end

    // Next pointers: restore overrides grant; frees always advance the tail.
    always_comb begin
        head_next = head_q;
        if (ckpt_restore) begin
            head_next = chk_q[ckpt_restore_id];
        end else if (gnt_c) begin
            head_next = head_q + PTR_W'(alloc_k);
        end
        tail_next  = tail_q + PTR_W'(free_m);
        count_next = tail_next - head_next;
    end

    // Entries, pointers, checkpoints and the registered occupancy outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entry_q[i] <= PR_W'(ARCH_REGS + i);
            end
            for (int c = 0; c < int'(NUM_CKPT); c++) begin
                chk_q[c] <= '0;
            end
            head_q     <= '0;
            tail_q     <= PTR_W'(DEPTH);
            free_count <= PTR_W'(DEPTH);
            empty      <= 1'b0;
        end else begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (free_en[i]) begin
                    entry_q[IDX_W'(tail_q[IDX_W-1:0] + IDX_W'(free_off[i*CNT_W +: CNT_W]))]
                        <= free_tag[i*PR_W +: PR_W];
                end
            end
            if (ckpt_save && !ckpt_restore) begin
                chk_q[ckpt_save_id] <= head_next;
            end
            head_q     <= head_next;
            tail_q     <= tail_next;
            free_count <= count_next;
            empty      <= (count_next == '0);
        end
    end

    // Retired tags may only fill slots that are actually vacant this cycle.
    assign ovf_need_c = EXT_W'(free_m) + EXT_W'(count_c);
    assign ovf_room_c = EXT_W'(DEPTH) + EXT_W'(gnt_c ? alloc_k : CNT_W'(0));

    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        ovf_need_c <= ovf_room_c);

    a_count_range: assert property (@(posedge clock) disable iff (reset)
        count_c <= PTR_W'(DEPTH));

endmodule

// File: tb/tb_freelist_ckpt.sv
// Directed bench for freelist_ckpt with a FIFO scoreboard for the wrap run.
module tb_freelist_ckpt;
    import freelist_pkg::*;

    localparam int unsigned W  = 3;
    localparam int unsigned PW = 6;

    logic            clock = 1'b0;
    logic            reset;
    logic [W-1:0]    alloc_req;
    logic            alloc_gnt;
    logic [W*PW-1:0] alloc_tag;
    logic [W-1:0]    free_en;
    logic [W*PW-1:0] free_tag;
    logic            ckpt_save;
    logic [1:0]      ckpt_save_id;
    logic            ckpt_restore;
    logic [1:0]      ckpt_restore_id;
    logic [5:0]      free_count;
    logic            empty;

    int checks = 0;
    int errors = 0;

    freelist_ckpt dut (
        .clock           (clock),
        .reset           (reset),
        .alloc_req       (alloc_req),
        .alloc_gnt       (alloc_gnt),
        .alloc_tag       (alloc_tag),
        .free_en         (free_en),
        .free_tag        (free_tag),
        .ckpt_save       (ckpt_save),
        .ckpt_save_id    (ckpt_save_id),
        .ckpt_restore    (ckpt_restore),
        .ckpt_restore_id (ckpt_restore_id),
        .free_count      (free_count),
        .empty           (empty)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int lane_tag(input int i);
        return int'(alloc_tag[i*PW +: PW]);
    endfunction

    function automatic logic [W*PW-1:0] tags3(input int t0, input int t1, input int t2);
        return {PW'(t2), PW'(t1), PW'(t0)};
    endfunction

    task automatic set_in(input logic [W-1:0] req, input logic [W-1:0] fen,
                          input logic [W*PW-1:0] ftag);
        alloc_req = req;
        free_en   = fen;
        free_tag  = ftag;
        #2;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        alloc_req       = '0;
        free_en         = '0;
        free_tag        = '0;
        ckpt_save       = 1'b0;
        ckpt_save_id    = '0;
        ckpt_restore    = 1'b0;
        ckpt_restore_id = '0;
    endtask

    task automatic check3(input string tag, input int e0, input int e1, input int e2);
        check({tag, "_l0"}, lane_tag(0), e0);
        check({tag, "_l1"}, lane_tag(1), e1);
        check({tag, "_l2"}, lane_tag(2), e2);
    endtask

    logic [W-1:0] req_tab [8] = '{3'b111, 3'b101, 3'b011, 3'b110, 3'b001, 3'b111, 3'b000, 3'b010};
    logic [W-1:0] fen_tab [8] = '{3'b000, 3'b011, 3'b111, 3'b100, 3'b010, 3'b101, 3'b111, 3'b001};

    initial begin
        int fq[$];
        int held[$];
        int pos;
        int k;
        int m;
        int uniq;
        bit exp_gnt;
        logic [63:0] seen;
        logic [W-1:0] req;
        logic [W-1:0] fen;
        logic [W*PW-1:0] ftag;

        reset           = 1'b1;
        alloc_req       = 3'b111;
        free_en         = '0;
        free_tag        = '0;
        ckpt_save       = 1'b0;
        ckpt_save_id    = '0;
        ckpt_restore    = 1'b0;
        ckpt_restore_id = '0;

        // reset: no grant while reset is high
        @(posedge clock);
        #1;
        check("gnt_in_reset", alloc_gnt, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // first allocation after reset
        set_in(3'b111, 3'b000, '0);
        check("rst_count", free_count, 32);
        check("rst_empty", empty, 0);
        check("gnt_111", alloc_gnt, 1);
        check3("tags_111", 32, 33, 34);
        tick();
        check("count_29", free_count, 29);

        // sparse request: lane1 idle gets 0
        set_in(3'b101, 3'b000, '0);
        check("gnt_101", alloc_gnt, 1);
        check3("tags_101", 35, 0, 36);
        tick();
        check("count_27", free_count, 27);

        // head advanced by exactly 2
        set_in(3'b001, 3'b000, '0);
        check("tag_37", lane_tag(0), 37);
        tick();

        // drain down to two free tags
        for (int c = 0; c < 8; c++) begin
            set_in(3'b111, 3'b000, '0);
            check3("drain", 38 + 3*c, 39 + 3*c, 40 + 3*c);
            tick();
        end
        check("count_2", free_count, 2);

        // k > count stalls; same-cycle free is not bypassed
        set_in(3'b111, 3'b001, tags3(32, 0, 0));
        check("stall_gnt", alloc_gnt, 0);
        check("stall_tags", int'(alloc_tag), 0);
        tick();
        check("count_3", free_count, 3);

        // retry succeeds across the index wrap
        set_in(3'b111, 3'b000, '0);
        check("retry_gnt", alloc_gnt, 1);
        check3("retry_tags", 62, 63, 32);
        tick();
        check("count_0", free_count, 0);
        check("empty_1", empty, 1);

        // empty list with frees arriving: still no grant this cycle
        set_in(3'b001, 3'b111, tags3(33, 34, 35));
        check("empty_gnt", alloc_gnt, 0);
        tick();
        check("count_3b", free_count, 3);
        check("empty_0", empty, 0);
        set_in(3'b000, 3'b111, tags3(36, 37, 38));
        tick();
        set_in(3'b000, 3'b101, tags3(39, 50, 40));
        tick();
        check("count_8", free_count, 8);

        // save captures the head after this cycle's grant
        ckpt_save    = 1'b1;
        ckpt_save_id = 2'd1;
        set_in(3'b001, 3'b000, '0);
        check("save_tag", lane_tag(0), 33);
        tick();
        set_in(3'b111, 3'b000, '0);
        check3("post_save_a", 34, 35, 36);
        tick();
        set_in(3'b111, 3'b000, '0);
        check3("post_save_b", 37, 38, 39);
        tick();
        check("count_1", free_count, 1);

        // restore suppresses allocation; free still lands
        ckpt_restore    = 1'b1;
        ckpt_restore_id = 2'd1;
        set_in(3'b001, 3'b001, tags3(41, 0, 0));
        check("restore_gnt", alloc_gnt, 0);
        check("restore_tag", lane_tag(0), 0);
        tick();
        check("restore_count", free_count, 8);
        set_in(3'b001, 3'b000, '0);
        check("restore_head", lane_tag(0), 34);
        tick();

        // save+restore same cycle: restore applies, save dropped
        ckpt_save    = 1'b1;
        ckpt_save_id = 2'd2;
        set_in(3'b000, 3'b000, '0);
        tick();
        set_in(3'b111, 3'b000, '0);
        check3("pre_dual", 35, 36, 37);
        tick();
        check("count_4", free_count, 4);
        ckpt_save       = 1'b1;
        ckpt_save_id    = 2'd1;
        ckpt_restore    = 1'b1;
        ckpt_restore_id = 2'd2;
        set_in(3'b000, 3'b000, '0);
        tick();
        check("dual_count", free_count, 7);
        set_in(3'b001, 3'b000, '0);
        check("dual_head", lane_tag(0), 35);
        tick();
        ckpt_restore    = 1'b1;
        ckpt_restore_id = 2'd1;
        set_in(3'b000, 3'b000, '0);
        tick();
        check("slot1_count", free_count, 8);
        set_in(3'b001, 3'b000, '0);
        check("slot1_kept", lane_tag(0), 34);
        tick();

        // reset mid-operation discards everything, including same-cycle frees
        reset = 1'b1;
        set_in(3'b111, 3'b111, tags3(1, 2, 3));
        tick();
        reset = 1'b1;
        set_in(3'b111, 3'b111, tags3(4, 5, 6));
        tick();
        reset = 1'b0;
        #2;
        check("rerst_count", free_count, 32);

        // scoreboard run across several index wraps
        for (int i = 0; i < 32; i++) fq.push_back(int'(FL_RESET_BASE) + i);
        for (int c = 0; c < 40; c++) begin
            req = req_tab[c % 8];
            fen = fen_tab[c % 8];
            m   = $countones(fen);
            if (m > held.size()) begin
                fen = '0;
                m   = 0;
            end
            ftag = '0;
            pos  = 0;
            for (int i = 0; i < int'(W); i++) begin
                if (fen[i]) begin
                    ftag[i*PW +: PW] = PW'(held[pos]);
                    pos++;
                end else begin
                    ftag[i*PW +: PW] = PW'(c);
                end
            end
            k       = $countones(req);
            exp_gnt = (k <= fq.size());
            set_in(req, fen, ftag);
            check("wrap_gnt", alloc_gnt, int'(exp_gnt));
            pos = 0;
            for (int i = 0; i < int'(W); i++) begin
                if (exp_gnt && req[i]) begin
                    check("wrap_tag", lane_tag(i), fq[pos]);
                    pos++;
                end else begin
                    check("wrap_idle", lane_tag(i), 0);
                end
            end
            tick();
            for (int j = 0; j < m; j++) fq.push_back(held.pop_front());
            if (exp_gnt) begin
                for (int j = 0; j < k; j++) held.push_back(fq.pop_front());
            end
            check("wrap_count", free_count, fq.size());
        end

        // drain everything: FIFO order, no duplicates, no losses
        for (int c = 0; c < 20 && fq.size() > 0; c++) begin
            req = (fq.size() >= 3) ? 3'b111 : (fq.size() == 2) ? 3'b011 : 3'b001;
            k   = $countones(req);
            set_in(req, 3'b000, '0);
            check("drain_gnt", alloc_gnt, 1);
            for (int i = 0; i < k; i++) begin
                check("drain_tag", lane_tag(i), fq[0]);
                held.push_back(fq.pop_front());
            end
            tick();
        end
        check("final_count", free_count, 0);
        check("final_empty", empty, 1);
        seen = '0;
        uniq = 0;
        foreach (held[i]) begin
            if (held[i] >= 0 && held[i] < 64 && !seen[held[i]]) begin
                seen[held[i]] = 1'b1;
                uniq++;
            end
        end
        check("unique_tags", uniq, 32);
        check("held_total", held.size(), 32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
